// File: rtl/bram_pixel_source_if.sv
//------------------------------------------------------------------------------
// Module      : bram_pixel_source_if
// Description : Raster strobes, RGB output, framebuffer and palette write bus
//               for bram_pixel_source.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface bram_pixel_source_if #(
    parameter int ADDR_W   = 15,
    parameter int PIX_BITS = 4
);
    logic                i_enable;
    logic                i_newline;
    logic                i_newframe;
    logic [7:0]          o_red;
    logic [7:0]          o_green;
    logic [7:0]          o_blue;
    logic                i_wr_valid;
    logic                o_wr_ready;
    logic [ADDR_W-1:0]   i_wr_addr;
    logic [PIX_BITS-1:0] i_wr_data;
    logic                i_pal_we;
    logic [PIX_BITS-1:0] i_pal_idx;
    logic [23:0]         i_pal_rgb;
    logic                o_overrun;

    modport master (
        output i_enable, i_newline, i_newframe,
        output i_wr_valid, i_wr_addr, i_wr_data,
        output i_pal_we, i_pal_idx, i_pal_rgb,
        input  o_red, o_green, o_blue, o_wr_ready, o_overrun
    );

    modport slave (
        input  i_enable, i_newline, i_newframe,
        input  i_wr_valid, i_wr_addr, i_wr_data,
        input  i_pal_we, i_pal_idx, i_pal_rgb,
        output o_red, o_green, o_blue, o_wr_ready, o_overrun
    );
endinterface

`default_nettype wire

// File: rtl/bram_pixel_source.sv
//------------------------------------------------------------------------------
// Module      : bram_pixel_source
// Description : Paletted BRAM framebuffer scaled by SCALE, feeding the HDMI
//               pixel stage. Optional macro WR_VSYNC_ONLY_EN limits writes
//               to vertical blanking.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bram_pixel_source #(
    parameter int FB_W     = 160,
    parameter int FB_H     = 120,
    parameter int SCALE    = 4,
    parameter int PIX_BITS = 4,
    parameter int ADDR_W   = 15
) (
    input  wire logic            clk,
    input  wire logic            rst,
    bram_pixel_source_if.slave   bus
);
    localparam int c_FB_SIZE = FB_W * FB_H;
    localparam int c_PAL_D   = 1 << PIX_BITS;
    localparam int c_SX_W    = $clog2(FB_W + 1);
    localparam int c_SUB_W   = $clog2(SCALE);
    localparam int c_SY_W    = $clog2(FB_H);

    localparam logic [c_SX_W-1:0]  c_SX_END   = c_SX_W'(FB_W);
    localparam logic [c_SX_W-1:0]  c_SX_LAST  = c_SX_W'(FB_W - 1);
    localparam logic [c_SX_W-1:0]  c_SX_ONE   = c_SX_W'(1);
    localparam logic [c_SUB_W-1:0] c_SUB_LAST = c_SUB_W'(SCALE - 1);
    localparam logic [c_SUB_W-1:0] c_SUB_ONE  = c_SUB_W'(1);
    localparam logic [c_SY_W-1:0]  c_SY_LAST  = c_SY_W'(FB_H - 1);
    localparam logic [c_SY_W-1:0]  c_SY_ONE   = c_SY_W'(1);
    localparam logic [ADDR_W-1:0]  c_LINE_INC = ADDR_W'(FB_W);
    localparam logic [ADDR_W-1:0]  c_ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]    c_FB_LIMIT = (ADDR_W + 1)'(c_FB_SIZE);

    function automatic logic [23:0] f_grey(input int idx);
        logic [7:0] v;
        v = 8'((idx * 255) / (c_PAL_D - 1));
        return {v, v, v};
    endfunction

    logic [c_SX_W-1:0]   r_sx;
    logic [c_SUB_W-1:0]  r_subx;
    logic [c_SY_W-1:0]   r_sy;
    logic [c_SUB_W-1:0]  r_suby;
    logic [ADDR_W-1:0]   r_line_base;
    logic [PIX_BITS-1:0] r_cur_idx;
    logic [PIX_BITS-1:0] r_next_idx;
    logic                r_prime;
    logic                r_prime2;
    logic                r_synced;
    logic                r_overrun;
    logic                r_wr_ready;
`ifdef WR_VSYNC_ONLY_EN
    logic                r_in_vblank;
`endif

    logic [PIX_BITS-1:0] r_mem [c_FB_SIZE];
    logic [23:0]         r_pal [c_PAL_D];

    logic                w_rd_en;
    logic [ADDR_W-1:0]   w_rd_addr;
    logic                w_wr_fire;
    logic [23:0]         w_rgb;

    // Prime fetch of a new line's first pixel wins over a same-cycle prefetch.
    always_comb begin
        w_rd_en   = 1'b0;
        w_rd_addr = r_line_base;
        if (r_prime) begin
            w_rd_en = 1'b1;
        end else if (bus.i_enable && (r_subx == '0) && (r_sx < c_SX_LAST)) begin
            w_rd_en   = 1'b1;
            w_rd_addr = r_line_base + ADDR_W'(r_sx) + c_ADDR_ONE;
        end
    end

    assign w_wr_fire = bus.i_wr_valid && r_wr_ready && ({1'b0, bus.i_wr_addr} < c_FB_LIMIT);

    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem[bus.i_wr_addr] <= bus.i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_next_idx <= '0;
        end else if (w_rd_en) begin
            r_next_idx <= r_mem[w_rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < c_PAL_D; i++) begin
                r_pal[i] <= f_grey(i);
            end
        end else if (bus.i_pal_we) begin
            r_pal[bus.i_pal_idx] <= bus.i_pal_rgb;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sx        <= '0;
            r_subx      <= '0;
            r_sy        <= '0;
            r_suby      <= '0;
            r_line_base <= '0;
            r_cur_idx   <= '0;
            r_prime     <= 1'b0;
            r_prime2    <= 1'b0;
            r_synced    <= 1'b0;
            r_overrun   <= 1'b0;
            r_wr_ready  <= 1'b0;
`ifdef WR_VSYNC_ONLY_EN
            r_in_vblank <= 1'b1;
`endif
        end else begin
            r_prime  <= 1'b0;
            r_prime2 <= r_prime;
            if (r_prime2) begin
                r_cur_idx <= r_next_idx;
            end
            if (bus.i_enable) begin
                if (r_sx == c_SX_END) begin
                    if (r_synced) begin
                        r_overrun <= 1'b1;
                    end
                end else if (r_subx == c_SUB_LAST) begin
                    r_subx    <= '0;
                    r_sx      <= r_sx + c_SX_ONE;
                    r_cur_idx <= r_next_idx;
                end else begin
                    r_subx <= r_subx + c_SUB_ONE;
                end
            end
            // Line/frame strobes override this cycle's horizontal advance.
            if (bus.i_newframe) begin
                r_sx        <= '0;
                r_subx      <= '0;
                r_sy        <= '0;
                r_suby      <= '0;
                r_line_base <= '0;
                r_prime     <= 1'b1;
                r_synced    <= 1'b1;
            end else if (bus.i_newline) begin
                r_sx    <= '0;
                r_subx  <= '0;
                r_prime <= 1'b1;
                if (r_suby == c_SUB_LAST) begin
                    r_suby <= '0;
                    if (r_sy == c_SY_LAST) begin
                        r_sy        <= '0;
                        r_line_base <= '0;
                    end else begin
                        r_sy        <= r_sy + c_SY_ONE;
                        r_line_base <= r_line_base + c_LINE_INC;
                    end
                end else begin
                    r_suby <= r_suby + c_SUB_ONE;
                end
            end
`ifdef WR_VSYNC_ONLY_EN
            if (bus.i_newframe) begin
                r_in_vblank <= 1'b1;
                r_wr_ready  <= 1'b1;
            end else if (bus.i_enable) begin
                r_in_vblank <= 1'b0;
                r_wr_ready  <= 1'b0;
            end else begin
                r_wr_ready  <= r_in_vblank;
            end
`else
            r_wr_ready <= 1'b1;
`endif
        end
    end

    assign w_rgb = (r_synced && (r_sx != c_SX_END)) ? r_pal[r_cur_idx] : 24'h000000;

    assign bus.o_red      = w_rgb[23:16];
    assign bus.o_green    = w_rgb[15:8];
    assign bus.o_blue     = w_rgb[7:0];
    assign bus.o_wr_ready = r_wr_ready;
    assign bus.o_overrun  = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_bram_pixel_source.sv
//------------------------------------------------------------------------------
// Module      : tb_bram_pixel_source
// Description : Self-checking bench for bram_pixel_source on a reduced raster.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_bram_pixel_source;
    localparam int FB_W     = 8;
    localparam int FB_H     = 6;
    localparam int SCALE    = 3;
    localparam int PIX_BITS = 4;
    localparam int ADDR_W   = 6;
    localparam int H_VIS    = FB_W * SCALE;
    localparam int V_VIS    = FB_H * SCALE;
    localparam int H_TOT    = H_VIS + 8;
    localparam int V_TOT    = V_VIS + 4;
    localparam int FB_SIZE  = FB_W * FB_H;
    localparam int PAL_D    = 1 << PIX_BITS;

    logic clk = 1'b0;
    logic rst = 1'b0;

    bram_pixel_source_if #(.ADDR_W(ADDR_W), .PIX_BITS(PIX_BITS)) bus ();

    bram_pixel_source #(
        .FB_W(FB_W), .FB_H(FB_H), .SCALE(SCALE), .PIX_BITS(PIX_BITS), .ADDR_W(ADDR_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          fb [FB_SIZE];
    logic [23:0] pal [PAL_D];
    bit          m_sync;
    bit          m_ov;
    bit          m_vblank;
    int          m_first;

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] rgb_out();
        return {bus.o_red, bus.o_green, bus.o_blue};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < PAL_D; i++) pal[i] = {3{8'(i * 17)}};
        m_sync   = 1'b0;
        m_ov     = 1'b0;
        m_vblank = 1'b1;
    endtask

    task automatic idle_inputs();
        bus.i_enable   = 1'b0;
        bus.i_newline  = 1'b0;
        bus.i_newframe = 1'b0;
        bus.i_wr_valid = 1'b0;
        bus.i_wr_addr  = '0;
        bus.i_wr_data  = '0;
        bus.i_pal_we   = 1'b0;
        bus.i_pal_idx  = '0;
        bus.i_pal_rgb  = '0;
    endtask

    task automatic wr(input int a, input int d);
        int waitc = 0;
        bus.i_wr_valid = 1'b1;
        bus.i_wr_addr  = ADDR_W'(a);
        bus.i_wr_data  = PIX_BITS'(d);
        @(negedge clk);
        while (!bus.o_wr_ready && waitc < 50) begin
            waitc++;
            @(negedge clk);
        end
        check("wr_accept", {23'd0, bus.o_wr_ready}, 24'd1);
        tick();
        if (a < FB_SIZE) fb[a] = d;
        bus.i_wr_valid = 1'b0;
    endtask

    task automatic pal_wr(input int idx, input logic [23:0] rgb);
        bus.i_pal_we  = 1'b1;
        bus.i_pal_idx = PIX_BITS'(idx);
        bus.i_pal_rgb = rgb;
        tick();
        pal[idx]     = rgb;
        bus.i_pal_we = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        model_reset();
        tick();
    endtask

    // One full raster; optional extra enables on line 0, a one-cycle reset
    // mid-line, and a write request raised at the start of a given line.
    task automatic drive_frame(input int extra, input int rst_line, input int wr_line,
                               input int wa, input int wd);
        bit wr_pend = 1'b0;
        for (int y = 0; y < V_TOT; y++) begin
            for (int x = 0; x < H_TOT; x++) begin
                int          lastx;
                bit          en, nl, nf, rst_now, fire, exp_rdy;
                logic [23:0] exp_rgb;
                lastx   = H_VIS - 1 + ((y == 0) ? extra : 0);
                en      = (y < V_VIS) && (x <= lastx);
                nl      = en && (x == lastx);
                nf      = nl && (y == V_VIS - 1);
                rst_now = (y == rst_line) && (x == 10);
                if (y == wr_line && x == 0) wr_pend = 1'b1;
                bus.i_enable   = en;
                bus.i_newline  = nl;
                bus.i_newframe = nf;
                rst            = !rst_now;
                bus.i_wr_valid = wr_pend;
                bus.i_wr_addr  = ADDR_W'(wa);
                bus.i_wr_data  = PIX_BITS'(wd);
                @(negedge clk);
                if (en) begin
                    exp_rgb = 24'h000000;
                    if (m_sync && x < H_VIS)
                        exp_rgb = (y == 0 && x < SCALE) ? pal[m_first]
                                : pal[fb[(y / SCALE) * FB_W + x / SCALE]];
                    check($sformatf("pixel(%0d,%0d)", x, y), rgb_out(), exp_rgb);
                    check("overrun", {23'd0, bus.o_overrun}, {23'd0, m_ov});
                end
                fire = 1'b0;
                if (wr_pend) begin
`ifdef WR_VSYNC_ONLY_EN
                    exp_rdy = m_vblank;
`else
                    exp_rdy = 1'b1;
`endif
                    check("wr_ready_hold", {23'd0, bus.o_wr_ready}, {23'd0, exp_rdy});
                    fire = bus.o_wr_ready;
                end
                @(posedge clk);
                if (rst_now) begin
                    model_reset();
                end else begin
                    if (fire) begin
                        fb[wa]  = wd;
                        wr_pend = 1'b0;
                    end
                    if (en && x >= H_VIS && m_sync) m_ov = 1'b1;
                    if (nf) begin
                        m_sync   = 1'b1;
                        m_vblank = 1'b1;
                        m_first  = fb[0];
                    end else if (en) begin
                        m_vblank = 1'b0;
                    end
                end
                #1;
            end
        end
        if (wr_line >= 0) check("wr_done", {23'd0, wr_pend}, 24'd0);
        idle_inputs();
        rst = 1'b1;
    endtask

    initial begin
        int a, d;
        for (int i = 0; i < FB_SIZE; i++) fb[i] = 0;
        m_first = 0;
        idle_inputs();
        model_reset();

        // Reset state
        rst = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_rgb", rgb_out(), 24'h000000);
        check("rst_overrun", {23'd0, bus.o_overrun}, 24'd0);
        check("rst_wr_ready", {23'd0, bus.o_wr_ready}, 24'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        tick();
        @(negedge clk);
        check("ready_after_rst", {23'd0, bus.o_wr_ready}, 24'd1);
        tick();

        // Blank framebuffer: first frame unsynced, second synced
        drive_frame(0, -1, -1, 0, 0);
        drive_frame(0, -1, -1, 0, 0);

        // Two source pixels on row 0
        wr(0, 'hF);
        wr(1, 'h1);
        drive_frame(0, -1, -1, 0, 0);

        // Custom palette entry at the last framebuffer location
        pal_wr(5, 24'h123456);
        wr(FB_SIZE - 1, 5);
        drive_frame(0, -1, -1, 0, 0);

        // Palette change visible on the very next cycle for the current index
        pal_wr(m_first, 24'($urandom));
        @(negedge clk);
        check("pal_next_cycle", rgb_out(), pal[m_first]);
        tick();

        // Reset mid-line, then resynchronise on the following frame
        drive_frame(0, V_VIS / 2, -1, 0, 0);
        drive_frame(0, -1, -1, 0, 0);

        // Random framebuffer/palette content, including discarded addresses
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 12; k++) begin
                a = $urandom_range(0, (1 << ADDR_W) - 1);
                d = $urandom_range(0, PAL_D - 1);
                wr(a, d);
            end
            for (int k = 0; k < 3; k++) pal_wr($urandom_range(0, PAL_D - 1), 24'($urandom));
            drive_frame(0, -1, -1, 0, 0);
        end

        // Overrun: extra enables on line 0, sticky until reset
        drive_frame(SCALE + 1, -1, -1, 0, 0);
        drive_frame(0, -1, -1, 0, 0);
        do_reset();
        @(negedge clk);
        check("overrun_cleared", {23'd0, bus.o_overrun}, {23'd0, m_ov});
        tick();
        drive_frame(0, -1, -1, 0, 0);

        // Write held during an active line
        drive_frame(0, -1, 10, $urandom_range(0, FB_W - 1), $urandom_range(1, PAL_D - 1));
        drive_frame(0, -1, -1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
